// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, WIDTH+1 edges from Start to Done; Start ignored unless IDLE.
// Optional SERIAL_ADDSUB_OVF_EN adds the signed-overflow output V.
module serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] S,
  output logic             cout,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             V,
`endif
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic             carry_nxt;
  logic             sum_bit;
  logic [CW-1:0]    cnt;
  logic             last;

  assign last = (cnt == CW'(WIDTH - 1));

  // The single full-adder cell.
  always_comb begin
    sum_bit   = opa[0] ^ opb[0] ^ carry;
    carry_nxt = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
    acc_nxt   = {sum_bit, acc[WIDTH-1:1]};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (Start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == ST_SHIFT);
    Done = (state == ST_DONE);
  end

  // Subtract is A + ~B + ~borrow_in, so only the load differs between modes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      V     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            opa   <= A;
            opb   <= Sub ? ~B : B;
            carry <= cin ^ Sub;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          acc   <= acc_nxt;
          carry <= carry_nxt;
          cnt   <= cnt + CW'(1);
          if (last) begin
            S    <= acc_nxt;
            cout <= carry_nxt;
`ifdef SERIAL_ADDSUB_OVF_EN
            V    <= carry ^ carry_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: vector table plus abort and Start-while-busy sequences.
module tb_serial_addsub;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic        Sub;
  logic [15:0] A;
  logic [15:0] B;
  logic        cin;
  logic [15:0] S;
  logic        cout;
  logic        Busy;
  logic        Done;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic        V;
`endif

  int checks = 0;
  int errors = 0;

  serial_addsub #(.WIDTH(16)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Sub   (Sub),
    .A     (A),
    .B     (B),
    .cin   (cin),
    .S     (S),
    .cout  (cout),
`ifdef SERIAL_ADDSUB_OVF_EN
    .V     (V),
`endif
    .Busy  (Busy),
    .Done  (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] s;
    logic        co;
    logic        v;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Launch one operation and follow it to Done (bounded); returns at the negedge inside the Done cycle.
  task automatic do_op(input logic sub, input logic [15:0] a, input logic [15:0] b, input logic c,
                       output int busy_cnt, output logic got_done, output logic s_moved);
    logic [15:0] s_prev;
    @(negedge Clk);
    Sub = sub; A = a; B = b; cin = c; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    Sub = ~sub; A = 16'($urandom); B = 16'($urandom); cin = ~c;
    busy_cnt = 0; got_done = 1'b0; s_moved = 1'b0; s_prev = S;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (Done) got_done = 1'b1;
      else begin
        if (Busy) busy_cnt++;
        if (S !== s_prev) s_moved = 1'b1;
        @(negedge Clk);
      end
    end
  endtask

  initial begin
    int          bc;
    logic        gd;
    logic        sm;
    logic [15:0] held;
    logic        seen_done;

    vecs[0] = '{1'b0, 16'hFF00, 16'hFFFF, 1'b1, 16'hFF00, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 16'h0002, 16'h0001, 1'b0, 16'h0001, 1'b1, 1'b0};

    Reset = 1'b1; Start = 1'b0; Sub = 1'b0; A = '0; B = '0; cin = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_S", 32'(S), 32'h0);
    chk("reset_cout", 32'(cout), 32'h0);
    chk("reset_busy", 32'(Busy), 32'h0);
    chk("reset_done", 32'(Done), 32'h0);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("reset_V", 32'(V), 32'h0);
`endif
    Reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].c, bc, gd, sm);
      chk($sformatf("v%0d_done", i), 32'(gd), 32'h1);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd16);
      chk($sformatf("v%0d_S_stable_while_busy", i), 32'(sm), 32'h0);
      chk($sformatf("v%0d_S", i), 32'(S), 32'(vecs[i].s));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].co));
`ifdef SERIAL_ADDSUB_OVF_EN
      chk($sformatf("v%0d_V", i), 32'(V), 32'(vecs[i].v));
`endif
      @(negedge Clk);
      chk($sformatf("v%0d_done_pulse_end", i), 32'({Done, Busy}), 32'h0);
    end

    // Result holds through idle cycles.
    held = S;
    repeat (4) @(negedge Clk);
    chk("idle_S_hold", 32'(S), 32'(held));

    // Second Start during the 5th Busy cycle must be ignored.
    @(negedge Clk);
    Sub = 1'b0; A = 16'h0003; B = 16'h0004; cin = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Sub = 1'b1; A = 16'hAAAA; B = 16'h1111; cin = 1'b1; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      if (Done) seen_done = 1'b1;
      else @(negedge Clk);
    end
    chk("busy_start_done", 32'(seen_done), 32'h1);
    chk("busy_start_S", 32'(S), 32'h0007);
    chk("busy_start_cout", 32'(cout), 32'h0);
    @(negedge Clk);
    chk("busy_start_idle", 32'({Done, Busy}), 32'h0);

    // Reset during the 8th Busy cycle aborts the operation.
    @(negedge Clk);
    Sub = 1'b0; A = 16'h1234; B = 16'h1111; cin = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (7) @(negedge Clk);
    chk("abort_busy_before", 32'(Busy), 32'h1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_S", 32'(S), 32'h0);
    chk("abort_cout", 32'(cout), 32'h0);
    chk("abort_busy", 32'(Busy), 32'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Done || Busy) seen_done = 1'b1;
      @(negedge Clk);
    end
    chk("abort_no_done", 32'(seen_done), 32'h0);
    do_op(1'b0, 16'h0001, 16'h0001, 1'b0, bc, gd, sm);
    chk("post_abort_done", 32'(gd), 32'h1);
    chk("post_abort_busy_cycles", 32'(bc), 32'd16);
    chk("post_abort_S", 32'(S), 32'h0002);
    chk("post_abort_cout", 32'(cout), 32'h0);

    repeat (2) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
